// File: rtl/mem.sv
// Single-port synchronous RAM: 2**ADDR words of WORD bits, registered read
// returning pre-edge contents, whole array and read register cleared by async reset.
module mem #(
  parameter int ADDR = 8,
  parameter int WORD = 8
) (
  input  logic            clk,
  input  logic [ADDR-1:0] addr,
  input  logic [WORD-1:0] data_in,
  input  logic            wr,
  output logic [WORD-1:0] data_out,
  input  logic            rst_n
);

  localparam int DEPTH = 1 << ADDR;

  logic [WORD-1:0] mem_q [DEPTH];
  logic [WORD-1:0] data_q;
  logic [WORD-1:0] data_d;
  logic            wr_en;

  // Read path samples the array before this edge's write lands (read-old-data).
  always_comb begin
    data_d = mem_q[addr];
    wr_en  = (wr == 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      data_q <= data_d;
      if (wr_en) begin
        mem_q[addr] <= data_in;
      end
    end
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_mem.sv
// Directed bench for mem (ADDR=4, WORD=4): reset, write/read latency,
// read-old-data collision, overwrite and boundary addresses, no-write, async reset.
`timescale 1ns/1ps
module tb_mem;

  localparam int ADDR  = 4;
  localparam int WORD  = 4;
  localparam int DEPTH = 1 << ADDR;

  logic            clk;
  logic            rst_n;
  logic [ADDR-1:0] addr;
  logic [WORD-1:0] data_in;
  logic            wr;
  logic [WORD-1:0] data_out;

  logic [WORD-1:0] model [DEPTH];
  int errors;
  int checks;

  mem #(.ADDR(ADDR), .WORD(WORD)) dut (
    .clk      (clk),
    .addr     (addr),
    .data_in  (data_in),
    .wr       (wr),
    .data_out (data_out),
    .rst_n    (rst_n)
  );

  // Clock and reset: period 2, inputs driven and outputs sampled on negedge.
  initial begin
    clk = 1'b0;
    forever #1 clk = ~clk;
  end

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // Driver tasks: called on a negedge, return on the following negedge.
  task automatic write_word(input logic [ADDR-1:0] a, input logic [WORD-1:0] d);
    addr = a; data_in = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    model[a] = d;
  endtask

  task automatic read_word(input logic [ADDR-1:0] a, output logic [WORD-1:0] d);
    addr = a; wr = 1'b0;
    @(negedge clk);
    d = data_out;
  endtask

  task automatic test_reset();
    logic [WORD-1:0] got;
    write_word(4'd1, 4'd5);
    write_word(4'd6, 4'd9);
    read_word(4'd1, got);
    checks++;
    if (got !== 4'd5) begin
      errors++; $display("FAIL reset_pre_read: got %0h want 5", got);
    end
    // Assert reset between edges while a write is being requested.
    addr = 4'd6; data_in = 4'd3; wr = 1'b1;
    #0.3 rst_n = 1'b0;
    #0.2;
    checks++;
    if (data_out !== 4'd0) begin
      errors++; $display("FAIL reset_immediate: data_out %0h want 0", data_out);
    end
    @(negedge clk);
    wr = 1'b0;
    rst_n = 1'b1;
    clear_model();
    for (int i = 0; i < DEPTH; i++) begin
      read_word(i[ADDR-1:0], got);
      checks++;
      if (got !== 4'd0) begin
        errors++; $display("FAIL reset_clear addr %0d: got %0h want 0", i, got);
      end
    end
  endtask

  task automatic test_write_read();
    logic [WORD-1:0] got;
    write_word(4'd2, 4'd7);
    write_word(4'd3, 4'd5);
    read_word(4'd2, got);
    checks++;
    if (got !== 4'd7) begin
      errors++; $display("FAIL write_read addr2: got %0h want 7", got);
    end
    read_word(4'd3, got);
    checks++;
    if (got !== 4'd5) begin
      errors++; $display("FAIL write_read addr3: got %0h want 5", got);
    end
  endtask

  task automatic test_read_old();
    write_word(4'd4, 4'd9);
    addr = 4'd4; data_in = 4'd6; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    model[4] = 4'd6;
    checks++;
    if (data_out !== 4'd9) begin
      errors++; $display("FAIL read_old first: got %0h want 9", data_out);
    end
    @(negedge clk);
    checks++;
    if (data_out !== 4'd6) begin
      errors++; $display("FAIL read_old second: got %0h want 6", data_out);
    end
  endtask

  task automatic test_overwrite();
    logic [WORD-1:0] got;
    write_word(4'd0, 4'd1);
    write_word(4'd15, 4'd15);
    write_word(4'd0, 4'd3);
    read_word(4'd0, got);
    checks++;
    if (got !== 4'd3) begin
      errors++; $display("FAIL overwrite addr0: got %0h want 3", got);
    end
    read_word(4'd15, got);
    checks++;
    if (got !== 4'd15) begin
      errors++; $display("FAIL boundary addr15: got %0h want f", got);
    end
    // Earlier content: 7@2, 5@3, 6@4, everything else 0.
    for (int i = 1; i < DEPTH - 1; i++) begin
      read_word(i[ADDR-1:0], got);
      checks++;
      if (got !== model[i]) begin
        errors++; $display("FAIL overwrite_others addr %0d: got %0h want %0h", i, got, model[i]);
      end
    end
  endtask

  task automatic test_no_write();
    logic [WORD-1:0] got;
    for (int i = 0; i < DEPTH; i++) begin
      addr = i[ADDR-1:0]; data_in = ~i[WORD-1:0]; wr = 1'b0;
      @(negedge clk);
      data_in = 4'ha;
    end
    // Unknown write enable must not write.
    addr = 4'd5; data_in = 4'hc; wr = 1'bx;
    @(negedge clk);
    wr = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      read_word(i[ADDR-1:0], got);
      checks++;
      if (got !== model[i]) begin
        errors++; $display("FAIL no_write addr %0d: got %0h want %0h", i, got, model[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [WORD-1:0] got;
    write_word(4'd8, 4'd11);
    write_word(4'd9, 4'd12);
    read_word(4'd8, got);
    checks++;
    if (got !== 4'd11) begin
      errors++; $display("FAIL burst_pre_read: got %0h want b", got);
    end
    addr = 4'd10; data_in = 4'd13; wr = 1'b1;
    #0.5 rst_n = 1'b0;
    #0.2;
    checks++;
    if (data_out !== 4'd0) begin
      errors++; $display("FAIL burst_reset_immediate: data_out %0h want 0", data_out);
    end
    @(negedge clk);
    wr = 1'b0;
    rst_n = 1'b1;
    clear_model();
    for (int i = 0; i < DEPTH; i++) begin
      read_word(i[ADDR-1:0], got);
      checks++;
      if (got !== 4'd0) begin
        errors++; $display("FAIL burst_reset_clear addr %0d: got %0h want 0", i, got);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b1;
    addr = '0; data_in = '0; wr = 1'b0;
    clear_model();
    #0.3 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_write_read();
    test_read_old();
    test_overwrite();
    test_no_write();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
